// File: rtl/seq_divider32_pkg.sv
// Shared definitions for seq_divider32: kpg carry codes, FSM states, width default.
// The SIGN state exists only when SIGNED_DIV_EN is defined.
package seq_divider32_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [7:0] KPG_K = 8'h6B;  // 'k' : carry killed
  localparam logic [7:0] KPG_P = 8'h70;  // 'p' : carry propagated
  localparam logic [7:0] KPG_G = 8'h67;  // 'g' : carry generated

  localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;

`ifdef SIGNED_DIV_EN
  typedef enum logic [2:0] {IDLE, RUN, FIXUP, DONE, SIGN} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, FIXUP, DONE} state_t;
`endif

  function automatic logic [7:0] kpg_cell(input logic a, input logic b);
    if (a & b) return KPG_G;
    if (a | b) return KPG_P;
    return KPG_K;
  endfunction

  // A higher-order span only defers to the lower span when it propagates.
  function automatic logic [7:0] kpg_merge(input logic [7:0] hi, input logic [7:0] lo);
    return (hi == KPG_P) ? lo : hi;
  endfunction

endpackage

// File: rtl/addsub33.sv
// N-bit (default 33) add/subtract on a kpg parallel-prefix carry network.
// Subtraction inverts b and injects a generate code as the carry-in.
module addsub33
  import seq_divider32_pkg::*;
#(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  localparam int L = $clog2(N);

  logic [N-1:0] bx;
  logic [N-1:0] c;
  logic [7:0]   pre [0:L][0:N-1];

  assign bx = sub ? ~b : b;

  // Element 0 is the carry-in, element j covers bit j-1; level L holds the carry into each bit.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int l = 0; l <= L; l++) pre[l][j] = KPG_K;
    end
    pre[0][0] = sub ? KPG_G : KPG_K;
    for (int j = 1; j < N; j++) pre[0][j] = kpg_cell(a[j-1], bx[j-1]);
    for (int l = 0; l < L; l++) begin
      for (int j = 0; j < N; j++) begin
        if (j >= (1 << l)) pre[l+1][j] = kpg_merge(pre[l][j], pre[l][j - (1 << l)]);
        else               pre[l+1][j] = pre[l][j];
      end
    end
    for (int i = 0; i < N; i++) c[i] = (pre[L][i] == KPG_G);
  end

  assign sum = a ^ bx ^ c;

endmodule

// File: rtl/seq_divider32.sv
// Radix-2 non-restoring sequential divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds a SIGN state).
module seq_divider32
  import seq_divider32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t state, state_nxt;
  logic   accept, div0;

  logic [5:0]              cnt;
  logic signed [WIDTH:0]   p;
  logic signed [WIDTH:0]   p_fix;
  logic [WIDTH-1:0]        q, d;
  logic [WIDTH-1:0]        dvd_in, dvs_in;
  logic [WIDTH:0]          as_a, as_b, as_sum;
  logic                    as_sub;

  assign div0 = (divisor == '0);

`ifdef SIGNED_DIV_EN
  logic neg_q, neg_r;
  assign dvd_in = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_in = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dvd_in = dividend;
  assign dvs_in = divisor;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = div0 ? DONE : RUN;
      RUN:        if (cnt == LAST) state_nxt = FIXUP;
`ifdef SIGNED_DIV_EN
      FIXUP:      state_nxt = SIGN;
      SIGN:       state_nxt = DONE;
`else
      FIXUP:      state_nxt = DONE;
`endif
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    busy   = 1'b0;
    case (state)
      IDLE, DONE: ready = 1'b1;
      default:    busy  = 1'b1;
    endcase
    accept = start & ready;
  end

  // One shared adder: RUN adds/subtracts D to the shifted P, FIXUP adds D back.
  always_comb begin
    as_a   = p;
    as_b   = {1'b0, d};
    as_sub = 1'b0;
    if (state == RUN) begin
      as_a   = {p[WIDTH-1:0], q[WIDTH-1]};
      as_sub = ~p[WIDTH];
    end
  end

  addsub33 #(.N(WIDTH + 1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  assign p_fix = p[WIDTH] ? as_sum : p;

  always_ff @(posedge clk) begin
    if (accept) begin
      q   <= dvd_in;
      d   <= dvs_in;
      p   <= '0;
      cnt <= '0;
`ifdef SIGNED_DIV_EN
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
`endif
    end else if (state == RUN) begin
      p   <= as_sum;
      q   <= {q[WIDTH-2:0], ~as_sum[WIDTH]};
      cnt <= cnt + 6'd1;
    end else if (state == FIXUP) begin
      p   <= p_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        div_by_zero <= div0;
        if (div0) begin
          quotient  <= WIDTH'(DIV0_QUOT);
          remainder <= dividend;
          done      <= 1'b1;
        end
      end
`ifdef SIGNED_DIV_EN
      if (state == SIGN) begin
        quotient  <= neg_q ? -q : q;
        remainder <= neg_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        done      <= 1'b1;
      end
`else
      if (state == FIXUP) begin
        quotient  <= q;
        remainder <= p_fix[WIDTH-1:0];
        done      <= 1'b1;
      end
`endif
    end
  end

endmodule
